// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the DDR request arbiter.
package ddr_arb_pkg;

   localparam int DDR_IDX_W = 19;
   localparam int LINE_W    = 512;
   localparam int WORD_W    = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Instruction lines are 8 words long, so the word index is aligned down to a line boundary
   function automatic logic [DDR_IDX_W-1:0] line_align(input logic [DDR_IDX_W-1:0] idx);
      return idx & ~19'h7;
   endfunction

endpackage

// File: rtl/ddr_arb_prio.sv
// Grant selection between IF and LS with a saturating LS-streak counter that
// lets a waiting IF request win once LS has been granted STARVE_LIMIT times in a row.
module ddr_arb_prio #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic grant_en,
   input  logic if_valid,
   input  logic ls_valid,
   output logic grant_if,
   output logic grant_ls
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] streak_r;
   logic          starve_s;

   // LS normally wins; a pending IF wins once the LS streak has saturated
   always_comb begin
      starve_s = (streak_r == CW'(STARVE_LIMIT));
      grant_if = grant_en && if_valid && (!ls_valid || starve_s);
      grant_ls = grant_en && ls_valid && !(if_valid && starve_s);
   end

   // Count consecutive LS grants, saturating at the limit, cleared by any IF grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         streak_r <= '0;
      end else if (grant_if) begin
         streak_r <= '0;
      end else if (grant_ls && !starve_s) begin
         streak_r <= streak_r + CW'(1);
      end
   end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Arbitrates IF line fetches and LS word accesses onto a single DDR port.
// One access at a time; DDR pins are held for the whole access and every
// issued access runs to completion, since the DDR cannot abort.
module ddr_req_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 if_req_valid,
   output logic                 if_req_ready,
   input  logic [DDR_IDX_W-1:0] if_req_index,
   input  logic                 if_flush,
   output logic                 if_resp_valid,
   output logic [LINE_W-1:0]    if_resp_data,
   input  logic                 ls_req_valid,
   output logic                 ls_req_ready,
   input  logic                 ls_req_write,
   input  logic [DDR_IDX_W-1:0] ls_req_index,
   input  logic [WORD_W-1:0]    ls_req_wdata,
   input  logic [WORD_W-1:0]    ls_req_wmask,
   output logic                 ls_resp_valid,
   output logic [WORD_W-1:0]    ls_resp_rdata,
   output logic                 ddr_chip_enable,
   output logic [DDR_IDX_W-1:0] ddr_index,
   output logic                 ddr_write_enable,
   output logic                 ddr_burst_mode,
   output logic [WORD_W-1:0]    ddr_opstore_write_mask,
   output logic [WORD_W-1:0]    ddr_opstore_write_data,
   output logic [LINE_W-1:0]    ddr_l2_write_data,
   input  logic [WORD_W-1:0]    ddr_opload_read_data,
   input  logic [LINE_W-1:0]    ddr_pc_read_inst,
   input  logic                 ddr_operation_done,
   input  logic                 ddr_ready
);

   arb_state_e state_r;
   arb_state_e next_s;
   logic       idle_s;
   logic       grant_if_s;
   logic       grant_ls_s;
   logic       drop_r;

   assign ddr_l2_write_data = {LINE_W{1'b0}};

   ddr_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clock    (clock),
      .reset    (reset),
      .grant_en (idle_s),
      .if_valid (if_req_valid),
      .ls_valid (ls_req_valid),
      .grant_if (grant_if_s),
      .grant_ls (grant_ls_s)
   );

   // Readiness only in IDLE, and withheld from the losing side on a grant cycle
   always_comb begin
      idle_s       = (state_r == IDLE) && !reset;
      if_req_ready = idle_s && !grant_ls_s;
      ls_req_ready = idle_s && !grant_if_s;
   end

   // Next-state: accept, wait for DDR idle, wait for completion, respond
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_if_s || grant_ls_s) next_s = ISSUE;
            else                          next_s = IDLE;
         end
         ISSUE: begin
            if (ddr_ready) next_s = WAIT;
            else           next_s = ISSUE;
         end
         WAIT: begin
            if (ddr_operation_done) next_s = RESP;
            else                    next_s = WAIT;
         end
         RESP:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= next_s;
   end

   // Start pulse: one cycle, only while the DDR reports idle; leaving ISSUE prevents a second pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ddr_chip_enable <= 1'b0;
      else       ddr_chip_enable <= (state_r == ISSUE) && ddr_ready;
   end

   // Capture the granted request straight into the DDR pin registers; held until the next grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ddr_index              <= '0;
         ddr_write_enable       <= 1'b0;
         ddr_burst_mode         <= 1'b0;
         ddr_opstore_write_mask <= '0;
         ddr_opstore_write_data <= '0;
      end else if (grant_if_s) begin
         ddr_index              <= line_align(if_req_index);
         ddr_write_enable       <= 1'b0;
         ddr_burst_mode         <= 1'b1;
         ddr_opstore_write_mask <= '0;
         ddr_opstore_write_data <= '0;
      end else if (grant_ls_s) begin
         ddr_index              <= ls_req_index;
         ddr_write_enable       <= ls_req_write;
         ddr_burst_mode         <= 1'b0;
         ddr_opstore_write_mask <= ls_req_wmask;
         ddr_opstore_write_data <= ls_req_wdata;
      end
   end

   // Remember a flush that hits an IF access in flight; cleared as the access retires
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_r <= 1'b0;
      end else if (state_r == RESP) begin
         drop_r <= 1'b0;
      end else if ((state_r != IDLE) && ddr_burst_mode && if_flush) begin
         drop_r <= 1'b1;
      end
   end

   // Read data captured on completion; response pulses issued from RESP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         ls_resp_valid <= 1'b0;
         ls_resp_rdata <= '0;
      end else begin
         if_resp_valid <= 1'b0;
         ls_resp_valid <= 1'b0;
         if ((state_r == WAIT) && ddr_operation_done) begin
            if (ddr_burst_mode)        if_resp_data  <= ddr_pc_read_inst;
            else if (ddr_write_enable) ls_resp_rdata <= '0;
            else                       ls_resp_rdata <= ddr_opload_read_data;
         end
         if (state_r == RESP) begin
            if (ddr_burst_mode) if_resp_valid <= !(drop_r || if_flush);
            else                ls_resp_valid <= 1'b1;
         end
      end
   end

endmodule
